// File: rtl/riscv_dmem_if.sv
// Core data-port bus between a RISC-V load/store unit and riscv_dmem.
// The core drives address, store data and the request strobes. The memory
// returns registered load data and a one-cycle valid pulse.
interface riscv_dmem_if;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] data_rd_data;
    logic        rd_valid;

    modport master (
        output data_addr,
        output data_wr_data,
        output mem_wr_en,
        output mem_rd_en,
        input  data_rd_data,
        input  rd_valid
    );

    modport slave (
        input  data_addr,
        input  data_wr_data,
        input  mem_wr_en,
        input  mem_rd_en,
        output data_rd_data,
        output rd_valid
    );
endinterface

// File: rtl/riscv_dmem.sv
// riscv_dmem: single-port word-addressed data memory for a RISC-V core.
// Loads have a latency of one cycle. Stores commit at the sampling edge.
// Out-of-window, misaligned or dual-strobe requests are rejected.
// A rejected request raises access_err one cycle later and increments a
// saturating error counter.
// Optional feature macro RISCV_DMEM_INIT_CLEAR_EN: after every reset the
// memory is zero-filled, one word per cycle, while busy is high.
// Without the macro the memory powers up in RUN and its contents are
// undefined until written.
module riscv_dmem #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic              clk,
    input  logic              rst,
    riscv_dmem_if.slave       bus,
    output logic              busy,
    output logic              access_err,
    output logic [15:0]       err_count
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          aligned;
    logic          any_req;
    logic          one_req;
    logic          run;
    logic          valid;
    logic          valid_wr;
    logic          valid_rd;
    logic          bad;

    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;

`ifdef RISCV_DMEM_INIT_CLEAR_EN
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] clr_ptr;
    logic [AW-1:0] next_clr_ptr;

    // State register and clear pointer; reset restarts the zero-fill sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            clr_ptr <= '0;
        end else begin
            state   <= next_state;
            clr_ptr <= next_clr_ptr;
        end
    end

    // Walk clr_ptr through every word, then leave INIT for good
    always_comb begin
        next_state   = state;
        next_clr_ptr = clr_ptr;
        case (state)
            INIT: begin
                next_clr_ptr = clr_ptr + 1'b1;
                if (clr_ptr == LAST_IDX) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                next_state = RUN;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    assign run  = (state == RUN);
    assign busy = (state == INIT);
`else
    assign run  = 1'b1;
    assign busy = 1'b0;
`endif

    // Request decode: the offset is unsigned, so addresses below the base wrap high and fail the range test
    always_comb begin
        offset   = bus.data_addr - BASE_ADDR;
        word_idx = offset[AW+1:2];
        in_range = (offset < SPAN);
        aligned  = (bus.data_addr[1:0] == 2'b00);
        any_req  = bus.mem_wr_en | bus.mem_rd_en;
        one_req  = bus.mem_wr_en ^ bus.mem_rd_en;
        valid    = one_req & in_range & aligned & run;
        valid_wr = valid & bus.mem_wr_en;
        valid_rd = valid & bus.mem_rd_en;
        bad      = any_req & ~valid;
    end

    // Single write port shared by the zero-fill sequence and core stores, suppressed while reset is held
    always_comb begin
        mem_we    = valid_wr;
        mem_widx  = word_idx;
        mem_wdata = bus.data_wr_data;
`ifdef RISCV_DMEM_INIT_CLEAR_EN
        if (state == INIT) begin
            mem_we    = 1'b1;
            mem_widx  = clr_ptr;
            mem_wdata = 32'h0;
        end
`endif
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    // Storage array; deliberately not reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // Registered load data, response pulses and the saturating error counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_rd_data <= 32'h0;
            bus.rd_valid     <= 1'b0;
            access_err       <= 1'b0;
            err_count        <= 16'h0;
        end else begin
            bus.rd_valid <= valid_rd;
            access_err   <= bad;
            if (valid_rd) begin
                bus.data_rd_data <= mem[word_idx];
            end
            if (bad && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/riscv_dmem.md
RISCV_DMEM -- requirements
Module: riscv_dmem

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words of storage (power of two, 16..65536).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_2000, meaning the byte address of word 0 (aligned to 4*DEPTH_WORDS).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port data_addr, input, 32 bits: byte address from the core data port.
REQ-006 The block SHALL have port data_wr_data, input, 32 bits: store data.
REQ-007 The block SHALL have port mem_wr_en, input, 1 bit: store request, sampled each cycle.
REQ-008 The block SHALL have port mem_rd_en, input, 1 bit: load request, sampled each cycle.
REQ-009 The block SHALL have port data_rd_data, output, 32 bits: registered load data.
REQ-010 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse marking data_rd_data as updated by a load.
REQ-011 The block SHALL have port busy, output, 1 bit: high while the block is in INIT.
REQ-012 The block SHALL have port access_err, output, 1 bit: one-cycle pulse flagging a rejected access.
REQ-013 The block SHALL have port err_count, output, 16 bits: saturating count of access_err pulses.

Function
REQ-014 An access SHALL be valid only when BASE_ADDR <= data_addr < BASE_ADDR+4*DEPTH_WORDS, data_addr[1:0]==2'b00, state is RUN, and exactly one of mem_wr_en/mem_rd_en is high.
REQ-015 Word index SHALL be (data_addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits.
REQ-016 A valid write SHALL update the addressed word at the sampling edge; no output changes.
REQ-017 A valid read SHALL load data_rd_data with the addressed word and pulse rd_valid in the cycle after the request (latency 1).
REQ-018 A read in the cycle after a write to the same word SHALL return the new data.
REQ-019 An invalid access (any enable high and REQ-014 unmet) SHALL leave memory unchanged, hold data_rd_data, keep rd_valid low, and pulse access_err in the following cycle.
REQ-020 Simultaneous mem_wr_en and mem_rd_en SHALL be treated as one invalid access: no write, no read.
REQ-021 Back-to-back requests SHALL be accepted every cycle; the block SHALL never stall.
REQ-022 err_count SHALL increment by 1 per access_err pulse and saturate at 16'hFFFF.
REQ-023 data_rd_data SHALL hold its value in all cycles without a valid read.
REQ-024 FSM SHALL have states INIT and RUN; INIT writes 32'h0 to word clr_ptr each cycle, clr_ptr counting 0..DEPTH_WORDS-1, and transitions to RUN in the cycle after writing word DEPTH_WORDS-1.
REQ-025 RUN SHALL be terminal until reset.

Reset
REQ-026 While rst is high: data_rd_data=32'h0, rd_valid=0, access_err=0, err_count=0, clr_ptr=0, state=INIT (RUN when the clear feature is compiled out), busy per state.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL abort all activity immediately; memory contents are not reset by rst directly.

Configuration
REQ-028 Macro RISCV_DMEM_INIT_CLEAR_EN defined: the INIT clear sequence of REQ-024 SHALL run after every reset, busy high for exactly DEPTH_WORDS cycles after rst deasserts.
REQ-029 Macro RISCV_DMEM_INIT_CLEAR_EN undefined: no INIT state or clr_ptr logic; state is RUN from reset, busy is constant 0, and memory contents are undefined until written.

Verification (DEPTH_WORDS=1024, BASE_ADDR=32'h2000, macro defined unless noted)
REQ-030 Release rst -> busy=1 for exactly 1024 cycles; then read 32'h2FFC -> data_rd_data=32'h0, rd_valid=1 one cycle later.
REQ-031 Write 32'h2004=32'hCAFEBABE, next cycle read 32'h2004 -> data_rd_data=32'hCAFEBABE with rd_valid the cycle after.
REQ-032 Read 32'h2006, then read 32'h3000 -> two access_err pulses, rd_valid=0, data_rd_data unchanged, err_count=2.
REQ-033 Write 32'h2008=32'h1234 with mem_rd_en also high -> access_err pulse; subsequent read 32'h2008 returns 32'h0.
REQ-034 Read 32'h2000 during INIT, then assert rst at INIT cycle 500 -> access_err pulse, then INIT restarts with busy high 1024 cycles from deassertion; err_count=0.
REQ-035 Macro undefined: busy=0 throughout; write 32'h2010=32'h5A5A5A5A then read -> 32'h5A5A5A5A at latency 1.
